// File: rtl/riscv_pkg.sv
// Shared definitions for the boot-time instruction loader.
package riscv_pkg;

  localparam int IMEM_BYTES = 8192;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  // Plain-vector state codes derived from the enum so both views stay in sync.
  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LEN_HI = LEN_HI;
  localparam logic [2:0] ST_LEN_LO = LEN_LO;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_CHK    = CHK;
  localparam logic [2:0] ST_DONE   = DONE;
  localparam logic [2:0] ST_ERR    = ERR;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface instr_loader_if #(
  parameter int ADDR_W = 13
);
  logic              s_valid_i;
  logic [7:0]        s_data_i;
  logic              s_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [7:0]        wdata_o;

  modport slave (
    input  s_valid_i,
    input  s_data_i,
    output s_ready_o,
    output we_o,
    output waddr_o,
    output wdata_o
  );

  modport master (
    output s_valid_i,
    output s_data_i,
    input  s_ready_o,
    input  we_o,
    input  waddr_o,
    input  wdata_o
  );
endinterface

// File: rtl/loader_chk.sv
// 8-bit running XOR of payload bytes; clear wins over enable.
module loader_chk (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] chk_o
);

  logic [7:0] r_chk;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= 8'h00;
    end else if (clr_i) begin
      r_chk <= 8'h00;
    end else if (en_i) begin
      r_chk <= r_chk ^ data_i;
    end
  end

  assign chk_o = r_chk;

endmodule

// File: rtl/instr_loader.sv
// Receives a length-framed byte stream, writes it into instruction memory from
// address 0, verifies the trailing XOR and releases the core only on success.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          start_i,
  instr_loader_if.slave bus,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          core_rst_n_o
);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_active;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_count;
  logic              r_done;
  logic              r_err;
  logic              r_core_rst_n;

  logic              w_xfer;
  logic              w_pay_xfer;
  logic              w_start_load;
  logic              w_last;
  logic              w_next_active;
  logic [LEN_W-1:0]  w_len_rx;
  logic [7:0]        w_chk;

  assign w_xfer        = bus.s_valid_i && r_active;
  assign w_pay_xfer    = w_xfer && (r_state == ST_DATA);
  assign w_start_load  = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERR));
  assign w_len_rx      = {r_len[LEN_W-1:8], bus.s_data_i};
  assign w_last        = (r_count == (r_len - LEN_W'(1)));
  assign w_next_active = (w_next == ST_LEN_HI) || (w_next == ST_LEN_LO) ||
                         (w_next == ST_DATA)   || (w_next == ST_CHK);

  // Lengths above the memory size are rejected before any write, so count never wraps.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_next = ST_LEN_HI;
      ST_LEN_HI: if (w_xfer) w_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len_rx == '0) begin
            w_next = ST_CHK;
          end else if (w_len_rx > LEN_W'(IMEM_BYTES)) begin
            w_next = ST_ERR;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA:   if (w_xfer && w_last) w_next = ST_CHK;
      ST_CHK:    if (w_xfer) w_next = (bus.s_data_i == w_chk) ? ST_DONE : ST_ERR;
      ST_DONE,
      ST_ERR:    if (start_i) w_next = ST_LEN_HI;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_active     <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= 8'h00;
      r_len        <= '0;
      r_count      <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= w_next_active;
      r_we     <= 1'b0;
      if (w_start_load) begin
        r_len        <= '0;
        r_count      <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_core_rst_n <= 1'b0;
      end
      if ((r_state == ST_LEN_HI) && w_xfer) begin
        r_len <= LEN_W'({bus.s_data_i, 8'h00});
      end
      if ((r_state == ST_LEN_LO) && w_xfer) begin
        r_len <= w_len_rx;
      end
      if (w_pay_xfer) begin
        r_we    <= 1'b1;
        r_waddr <= r_count[ADDR_W-1:0];
        r_wdata <= bus.s_data_i;
        r_count <= r_count + LEN_W'(1);
      end
      if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
        r_done       <= 1'b1;
        r_core_rst_n <= 1'b1;
      end
      if ((w_next == ST_ERR) && (r_state != ST_ERR)) begin
        r_err <= 1'b1;
      end
    end
  end

  loader_chk u_chk (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .clr_i  (w_start_load),
    .en_i   (w_pay_xfer),
    .data_i (bus.s_data_i),
    .chk_o  (w_chk)
  );

  assign bus.s_ready_o = r_active;
  assign bus.we_o      = r_we;
  assign bus.waddr_o   = r_waddr;
  assign bus.wdata_o   = r_wdata;
  assign busy_o        = r_active;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign core_rst_n_o  = r_core_rst_n;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frames are built from random or fixed
// payloads and the expected writes/status come from the framing rules alone.
module tb_instr_loader;

  logic clk;
  logic rstN;
  logic start;
  logic busy;
  logic done;
  logic err;
  logic coreRstN;

  int checks = 0;
  int errors = 0;

  logic [12:0] obsAddr[$];
  logic [7:0]  obsData[$];
  logic [7:0]  fixedBytes[$];

  instr_loader_if #(.ADDR_W(13)) bus ();

  instr_loader #(.ADDR_W(13), .LEN_W(16)) dut (
    .clk_i        (clk),
    .rst_n        (rstN),
    .start_i      (start),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .core_rst_n_o (coreRstN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write pulse seen on the memory bus, in order.
  always @(negedge clk) begin
    if (rstN && bus.we_o) begin
      obsAddr.push_back(bus.waddr_o);
      obsData.push_back(bus.wdata_o);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte (optionally after random idle gaps) and, for payload bytes,
  // checks the write one cycle after acceptance.
  task automatic applyStimulus(input logic [7:0] b, input bit payload, input int expAddr,
                               input bit gaps);
    int gapCnt = 0;
    int waitCyc = 0;
    while (gaps && gapCnt < 3 && $urandom_range(1, 0) == 1) begin
      bus.s_valid_i = 1'b0;
      @(negedge clk);
      gapCnt++;
    end
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = b;
    while (!bus.s_ready_o && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("ready_wait", bus.s_ready_o, 1);
    @(posedge clk);
    #1;
    if (payload) begin
      checkOutput("wr_pulse", bus.we_o, 1);
      checkOutput("wr_addr_lat", bus.waddr_o, expAddr);
      checkOutput("wr_data_lat", bus.wdata_o, b);
    end else begin
      checkOutput("no_wr_hdr", bus.we_o, 0);
    end
    @(negedge clk);
    bus.s_valid_i = 1'b0;
  endtask

  // chkMode: 0 correct checksum, 1 checksum with bit 0 flipped, 2 forcedChk.
  task automatic runFrame(input int n, input bit useFixed, input int chkMode,
                          input logic [7:0] forcedChk, input bit gaps, input bit midStart);
    logic [7:0]  payload[$];
    logic [7:0]  x;
    logic [7:0]  b;
    logic [7:0]  chkByte;
    logic [15:0] n16;
    bit          fits;
    bit          good;
    int          expWrites;
    payload = {};
    x = 8'h00;
    chkByte = 8'h00;
    n16 = n[15:0];
    fits = (n <= 8192);
    obsAddr.delete();
    obsData.delete();
    pulseStart();
    applyStimulus(n16[15:8], 1'b0, 0, gaps);
    applyStimulus(n16[7:0], 1'b0, 0, gaps);
    if (fits) begin
      for (int i = 0; i < n; i++) begin
        b = useFixed ? fixedBytes[i] : 8'($urandom);
        payload.push_back(b);
        x = x ^ b;
        if (midStart && i == n / 2) start = 1'b1;
        applyStimulus(b, 1'b1, i, gaps);
        start = 1'b0;
      end
      chkByte = (chkMode == 0) ? x : (chkMode == 1) ? (x ^ 8'h01) : forcedChk;
      applyStimulus(chkByte, 1'b0, 0, gaps);
    end
    repeat (3) @(negedge clk);
    good = fits && (chkByte == x);
    expWrites = fits ? n : 0;
    checkOutput("write_count", obsAddr.size(), expWrites);
    for (int i = 0; i < obsAddr.size() && i < payload.size(); i++) begin
      checkOutput("mem_addr", obsAddr[i], i);
      checkOutput("mem_data", obsData[i], payload[i]);
    end
    checkOutput("done", done, good);
    checkOutput("err", err, !good);
    checkOutput("core_rst_n", coreRstN, good);
    checkOutput("busy_idle", busy, 0);
    checkOutput("ready_idle", bus.s_ready_o, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, bus.s_ready_o, 0);
    checkOutput({tag, "_we"}, bus.we_o, 0);
    checkOutput({tag, "_waddr"}, bus.waddr_o, 0);
    checkOutput({tag, "_wdata"}, bus.wdata_o, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_core_rst_n"}, coreRstN, 0);
  endtask

  initial begin
    rstN = 1'b0;
    start = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = 8'h00;
    #2;
    checkResetValues("reset");
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] good N=4 frame");
    fixedBytes = '{8'h00, 8'h13, 8'h05, 8'h00};
    runFrame(4, 1'b1, 2, 8'h16, 1'b0, 1'b0);

    $display("[TB] bad checksum N=4 frame");
    runFrame(4, 1'b1, 2, 8'h17, 1'b0, 1'b0);

    $display("[TB] oversize length");
    runFrame(8193, 1'b0, 0, 8'h00, 1'b0, 1'b0);

    $display("[TB] empty frames");
    runFrame(0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
    runFrame(0, 1'b0, 2, 8'h5A, 1'b0, 1'b0);

    $display("[TB] N=16 with valid gaps and mid-load start");
    runFrame(16, 1'b0, 0, 8'h00, 1'b1, 1'b1);

    $display("[TB] reset during payload");
    obsAddr.delete();
    obsData.delete();
    pulseStart();
    applyStimulus(8'h00, 1'b0, 0, 1'b0);
    applyStimulus(8'h08, 1'b0, 0, 1'b0);
    applyStimulus(8'($urandom), 1'b1, 0, 1'b0);
    applyStimulus(8'($urandom), 1'b1, 1, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (3) @(negedge clk);
    checkOutput("midreset_writes", obsAddr.size(), 2);
    rstN = 1'b1;
    @(negedge clk);
    runFrame(8, 1'b0, 0, 8'h00, 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      runFrame($urandom_range(20, 1), 1'b0, $urandom_range(1, 0), 8'h00, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the 8 KB byte-wide instruction memory that the fetch path reads. Fetch assembles each 32-bit instruction from mem[PC] (bits 31:24) through mem[PC+3] (bits 7:0).
- This block receives a framed byte stream over a valid/ready handshake and writes each payload byte sequentially from address 0. Stream order therefore equals fetch big-endian byte order.
- It verifies a trailing XOR checksum and holds the core in reset until a load completes cleanly.

Parameters:
- ADDR_W, 13, byte-address width of the instruction memory (depth 2^ADDR_W = 8192).
- LEN_W, 16, width of the length header field.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request to begin a load.
- s_valid_i  in  1  input byte valid.
- s_data_i  in  8  input byte.
- s_ready_o  out  1  loader accepts a byte this cycle.
- we_o  out  1  memory byte write enable.
- waddr_o  out  ADDR_W  memory byte address.
- wdata_o  out  8  memory byte data.
- busy_o  out  1  load in progress.
- done_o  out  1  last load completed with a good checksum.
- err_o  out  1  last load failed (length overflow or checksum mismatch).
- core_rst_n_o  out  1  active-low reset to the CPU core; high only after a successful load.

Behaviour:
- Reset values, asynchronous on rst_n low: state=IDLE, s_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, core_rst_n_o=0. Internal len, count and chk registers are cleared.
- Frame format: LEN_HI, LEN_LO (byte count N, big-endian), N payload bytes, then 1 checksum byte. The checksum is the XOR of all payload bytes.
- Handshake: a byte transfers when s_valid_i && s_ready_o. s_ready_o is a registered output, 1 only in LEN_HI, LEN_LO, DATA and CHK. The source may hold s_valid_i high indefinitely; stalls on valid=0 are unbounded.
- FSM transitions:
  - IDLE -> LEN_HI on start_i.
  - DONE -> LEN_HI and ERR -> LEN_HI on start_i (restart); start_i is ignored in every other state.
  - LEN_HI -> LEN_LO on transfer.
  - LEN_LO -> DATA if N in 1..8192; -> CHK if N=0; -> ERR if N>8192, with no writes issued.
  - DATA -> CHK when the Nth payload byte transfers.
  - CHK -> DONE if the received byte equals the running XOR, else -> ERR.
- Write latency: a payload byte accepted in cycle k produces we_o=1 in cycle k+1, with waddr_o=count and wdata_o=byte. we_o is a single-cycle pulse per byte, so back-to-back transfers give one write per cycle.
- Addressing: count starts at 0 for each load and increments per payload byte, reaching at most 8191. No wrap occurs because the N>8192 case is rejected.
- Restart:
  - On entering LEN_HI, clear count and chk, and clear done_o and err_o.
  - Drive core_rst_n_o=0 during the whole load.
- Status outputs: busy_o=1 in LEN_HI, LEN_LO, DATA and CHK. In DONE, done_o=1 and core_rst_n_o=1; these hold until the next start. In ERR, err_o=1 and core_rst_n_o=0.
- Reset mid-load: everything returns to reset values and no further writes occur. Memory contents written so far are left as is.

Decomposition:
- Shared package (riscv_pkg): the loader_state_e enum (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR) and the constant IMEM_BYTES=8192.
- One natural sub-module: loader_chk, an 8-bit XOR accumulator with clear and enable inputs.

Test Plan:
- Load N=4, bytes 00 13 05 00 + chk 0x16 -> writes mem[0..3]=00,13,05,00 in 4 consecutive cycles (each 1 cycle after acceptance), then done_o=1, core_rst_n_o=1, err_o=0.
- Same frame with chk byte 0x17 -> all 4 writes occur, then err_o=1, done_o=0, core_rst_n_o stays 0.
- Header 0x20 0x01 (N=8193) -> ERR right after LEN_LO, zero writes.
- N=0 then chk 0x00 -> DONE with no writes. N=0 then chk 0x5A -> ERR.
- Random valid gaps (around 50% duty) on an N=16 frame -> writes to addresses 0..15 in order with correct data, exactly one we_o pulse per byte. start_i pulsed mid-DATA is ignored.
- rst_n asserted during DATA after 2 of 8 bytes -> all outputs take reset values immediately. A new start_i plus a full N=8 frame then completes DONE with addresses restarting at 0.
